// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready data-memory responder with fixed latency and one access in flight.
// Optional macro DMEM_MISALIGN_CHECK_EN flags misaligned half/word accesses via rsp_err.
module dmem_responder #(
  parameter int ADDR_W = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);
  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [31:0] mem [DEPTH_WORDS];
  logic we_q, uns_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0] size_q;
  logic go, wr, a_we, a_uns, mis, bad, unused;
  logic [ADDR_W-1:0] a_addr;
  logic [31:0] a_wdata, wrep, rword, rd;
  logic [1:0] a_size, lane;
  logic [IW-1:0] idx;
  logic [3:0] mask;
  logic [7:0] rb;
  logic [15:0] rh;
  assign req_ready = state == IDLE;
  assign busy = state != IDLE;
  assign rsp_valid = state == RESP;
  assign rsp_err = err_q;
  // With LATENCY==1 the access happens on the accept edge, so use the live request.
  assign a_we = req_ready ? req_we : we_q;
  assign a_addr = req_ready ? req_addr : addr_q;
  assign a_wdata = req_ready ? req_wdata : wdata_q;
  assign a_size = req_ready ? req_size : size_q;
  assign a_uns = req_ready ? req_unsigned : uns_q;
  assign go = !reset && ((req_ready && req_valid && LATENCY == 1) || (state == WAIT && cnt == '0));
  assign wr = go && a_we && !bad;
  assign unused = ^{a_addr, mis};
  always_comb begin
    idx = a_addr[IW+1:2];
    lane = a_addr[1:0];
    mis = (a_size == 2'b01 && lane[0]) || (a_size[1] && lane != 2'b00);
    mask = a_size[1] ? 4'hf : a_size[0] ? (lane[1] ? 4'hc : 4'h3) : 4'h1 << lane;
    wrep = a_size[1] ? a_wdata : a_size[0] ? {2{a_wdata[15:0]}} : {4{a_wdata[7:0]}};
    rword = mem[idx];
    rb = rword[{lane, 3'b000} +: 8];
    rh = lane[1] ? rword[31:16] : rword[15:0];
    rd = a_we ? '0 : a_size[1] ? rword :
         a_size[0] ? {{16{rh[15] & !a_uns}}, rh} : {{24{rb[7] & !a_uns}}, rb};
  end
`ifdef DMEM_MISALIGN_CHECK_EN
  assign bad = mis;
`else
  assign bad = 1'b0;
`endif
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (wr && mask[i]) mem[idx][8*i +: 8] <= wrep[8*i +: 8];
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      rsp_rdata <= '0;
      err_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (req_valid) begin
          we_q <= req_we;
          addr_q <= req_addr;
          wdata_q <= req_wdata;
          size_q <= req_size;
          uns_q <= req_unsigned;
          cnt <= CW'(LATENCY - 2);
          state <= LATENCY == 1 ? RESP : WAIT;
        end
        WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt == '0) state <= RESP;
        end
        RESP: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (go) begin
        rsp_rdata <= bad ? '0 : rd;
        err_q <= bad;
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of dmem_responder against a byte-array model.
module tb_dmem_responder;
  localparam int LAT = 2;
  logic clk = 0, reset = 1;
  logic req_valid = 0, req_ready, req_we = 0, req_unsigned = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [1:0] req_size = 0;
  logic rsp_valid, rsp_ready = 0, rsp_err, busy;
  logic [31:0] rsp_rdata;
  int checks = 0, failures = 0;
  logic [7:0] mb [4096];

  dmem_responder #(.ADDR_W(32), .DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy));

  always #5 clk = ~clk;

  task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns,
                       output logic [31:0] ed, output logic ee);
    int n, ea, base;
    n = size[1] ? 4 : size[0] ? 2 : 1;
    ea = int'(addr[11:0]);
    base = ea & ~(n - 1);
    ed = 0;
    ee = 0;
`ifdef DMEM_MISALIGN_CHECK_EN
    if (ea % n != 0) begin
      ee = 1;
      return;
    end
`endif
    if (we) for (int i = 0; i < n; i++) mb[base + i] = wdata[8*i +: 8];
    else begin
      for (int i = 0; i < n; i++) ed = ed | (32'(mb[base + i]) << (8 * i));
      if (!uns && n < 4 && ed[8*n-1]) ed = ed | (32'hFFFF_FFFF << (8 * n));
    end
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns, input int hold,
                        output logic [31:0] got);
    logic [31:0] ed, held;
    logic ee;
    int lat, guard;
    model(we, addr, wdata, size, uns, ed, ee);
    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata; req_size = size; req_unsigned = uns;
    @(posedge clk); #1;
    req_valid = 0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    req_size = 2'($urandom); req_unsigned = 1'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== LAT) begin failures++; $display("FAIL latency addr=%h got=%0d exp=%0d", addr, lat, LAT); end
    checks++;
    if (rsp_rdata !== ed) begin failures++; $display("FAIL rdata addr=%h we=%b size=%b got=%h exp=%h", addr, we, size, rsp_rdata, ed); end
    checks++;
    if (rsp_err !== ee) begin failures++; $display("FAIL err addr=%h got=%b exp=%b", addr, rsp_err, ee); end
    got = rsp_rdata;
    held = rsp_rdata;
    for (int c = 0; c < hold; c++) begin
      req_valid = c == 1; req_we = 1; req_addr = 32'h40; req_wdata = 32'h0BAD_0BAD; req_size = 2'b10;
      @(posedge clk); #1;
      req_valid = 0;
      checks++;
      if (rsp_valid !== 1 || rsp_rdata !== held || req_ready !== 0 || busy !== 1) begin
        failures++;
        $display("FAIL stall c=%0d valid=%b rdata=%h ready=%b busy=%b exp 1 %h 0 1", c, rsp_valid, rsp_rdata, req_ready, busy, held);
      end
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    checks++;
    if (rsp_valid !== 0 || req_ready !== 1) begin failures++; $display("FAIL handshake valid=%b ready=%b exp 0 1", rsp_valid, req_ready); end
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 0 || rsp_rdata !== 0 || rsp_err !== 0 || req_ready !== 1 || busy !== 0) begin
      failures++;
      $display("FAIL reset valid=%b rdata=%h err=%b ready=%b busy=%b exp 0 0 0 1 0", rsp_valid, rsp_rdata, rsp_err, req_ready, busy);
    end
    reset = 0;
  endtask

  task automatic test_fill();
    logic [31:0] g;
    for (int w = 0; w < 1024; w++) do_req(1, 32'(w * 4), $urandom, 2'b10, 0, 0, g);
  endtask

  task automatic test_basic();
    logic [31:0] g;
    do_req(1, 32'h10, 32'hDEAD_BEEF, 2'b10, 0, 0, g);
    do_req(0, 32'h10, 0, 2'b10, 0, 0, g);
    checks++; if (g !== 32'hDEAD_BEEF) begin failures++; $display("FAIL word got=%h exp=DEADBEEF", g); end
    do_req(1, 32'h11, 32'h80, 2'b00, 0, 0, g);
    do_req(0, 32'h11, 0, 2'b00, 0, 0, g);
    checks++; if (g !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb got=%h exp=FFFFFF80", g); end
    do_req(0, 32'h11, 0, 2'b00, 1, 0, g);
    checks++; if (g !== 32'h0000_0080) begin failures++; $display("FAIL lbu got=%h exp=00000080", g); end
    do_req(0, 32'h10, 0, 2'b10, 0, 0, g);
    checks++; if (g !== 32'hDEAD_80EF) begin failures++; $display("FAIL merged got=%h exp=DEAD80EF", g); end
    do_req(0, 32'h12, 0, 2'b01, 0, 0, g);
    checks++; if (g !== 32'hFFFF_DEAD) begin failures++; $display("FAIL lh got=%h exp=FFFFDEAD", g); end
  endtask

  task automatic test_stall();
    logic [31:0] g;
    do_req(0, 32'h10, 0, 2'b10, 0, 5, g);
    do_req(0, 32'h40, 0, 2'b10, 0, 0, g);
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] g;
    do_req(1, 32'h20, 32'h1234_5678, 2'b10, 0, 0, g);
    @(negedge clk);
    req_valid = 1; req_we = 1; req_addr = 32'h20; req_wdata = 32'hCAFE_F00D; req_size = 2'b10;
    @(posedge clk); #1;
    req_valid = 0;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    checks++;
    if (rsp_valid !== 0 || req_ready !== 1 || busy !== 0) begin
      failures++;
      $display("FAIL reset_wait valid=%b ready=%b busy=%b exp 0 1 0", rsp_valid, req_ready, busy);
    end
    do_req(0, 32'h20, 0, 2'b10, 0, 0, g);
    checks++; if (g !== 32'h1234_5678) begin failures++; $display("FAIL dropped_store got=%h exp=12345678", g); end
  endtask

  task automatic test_wrap();
    logic [31:0] g;
    do_req(1, 32'h1000, 32'hA5A5_A5A5, 2'b10, 0, 0, g);
    do_req(0, 32'h0, 0, 2'b10, 0, 0, g);
    checks++; if (g !== 32'hA5A5_A5A5) begin failures++; $display("FAIL wrap got=%h exp=A5A5A5A5", g); end
  endtask

  task automatic test_misalign();
    logic [31:0] g;
    do_req(1, 32'h10, 32'hAABB_CCDD, 2'b10, 0, 0, g);
    do_req(0, 32'h13, 0, 2'b01, 0, 0, g);
`ifdef DMEM_MISALIGN_CHECK_EN
    checks++; if (g !== 32'h0) begin failures++; $display("FAIL misalign got=%h exp=00000000", g); end
`else
    checks++; if (g !== 32'hFFFF_AABB) begin failures++; $display("FAIL misalign got=%h exp=FFFFAABB", g); end
`endif
  endtask

  task automatic test_random();
    logic [31:0] g;
    for (int i = 0; i < 300; i++)
      do_req(1'($urandom), $urandom, $urandom, 2'($urandom), 1'($urandom), 0, g);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_basic();
    test_stall();
    test_reset_in_wait();
    test_wrap();
    test_misalign();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
